sram_axi4_s: RTL

AXI4 slave SRAM: the responder end of the SRAM AXI4 link, paired with the SRAM AXI4 master traffic generator. It holds a word-addressed, byte-strobed memory of `2**ADDR_WIDTH` words. Read and write channels are serviced independently by two FSMs, with FIXED/INCR/WRAP bursts. Every burst returns an AXI response.

---
 rtl/sram_axi4_s.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sram_axi4_s.sv
// AXI4 slave backed by a word-addressed, byte-strobed SRAM.
// Independent read and write FSMs; FIXED/INCR/WRAP bursts, SLVERR for bad bursts.
module sram_axi4_s #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_rd_state,
    output logic [1:0]              o_wr_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never drops before that edge, and ready depends only on state.
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        case (burst)
            2'b11:   return 1'b1;
            2'b10:   return !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        mask = ADDR_WIDTH'(len);
        inc  = addr + ADDR_WIDTH'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
    logic [7:0]            r_len, r_beat;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    assign r_last     = (r_beat == r_len);
    assign r_addr_nxt = next_addr(r_addr, r_len, r_burst);

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (i_arvalid) r_next = R_DATA;
            R_DATA:  if (i_rready && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read data is captured at the edge that accepts the address or beat, so a
    // write landing on the same edge is not visible until the following beat.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else if (r_state == R_IDLE && i_arvalid) begin
            r_addr  <= i_araddr;
            r_len   <= i_arlen;
            r_burst <= i_arburst;
            r_beat  <= '0;
            r_err   <= burst_err(i_arburst, i_arlen);
            r_data  <= burst_err(i_arburst, i_arlen) ? '0 : mem[i_araddr];
        end else if (r_state == R_DATA && i_rready) begin
            if (!r_last) begin
                r_addr <= r_addr_nxt;
                r_beat <= r_beat + 8'd1;
                r_data <= r_err ? '0 : mem[r_addr_nxt];
            end else begin
                r_data <= '0;
            end
        end
    end

    assign o_arready  = (r_state == R_IDLE);
    assign o_rvalid   = (r_state == R_DATA);
    assign o_rlast    = o_rvalid && r_last;
    assign o_rresp    = (o_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign o_rdata    = r_data;
    assign o_rd_state = r_state;

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_beat;
    logic [1:0]            w_burst;
    logic                  w_err, w_bad;
    logic                  w_at_end;

    assign w_at_end = (w_beat == w_len);

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (i_awvalid) w_next = W_DATA;
            W_DATA:  if (i_wvalid && w_at_end) w_next = W_RESP;
            W_RESP:  if (i_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_bad   <= 1'b0;
        end else if (w_state == W_IDLE && i_awvalid) begin
            w_addr  <= i_awaddr;
            w_len   <= i_awlen;
            w_burst <= i_awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_bad   <= burst_err(i_awburst, i_awlen);
        end else if (w_state == W_DATA && i_wvalid) begin
            if (i_wlast != w_at_end) w_err <= 1'b1;
            w_addr <= next_addr(w_addr, w_len, w_burst);
            w_beat <= w_beat + 8'd1;
        end
    end

    // Memory has no reset; the async reset forces W_IDLE, which blocks writes.
    always_ff @(posedge i_aclk) begin
        if (w_state == W_DATA && i_wvalid && !w_bad) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (i_wstrb[b]) mem[w_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_awready  = (w_state == W_IDLE);
    assign o_wready   = (w_state == W_DATA);
    assign o_bvalid   = (w_state == W_RESP);
    assign o_bresp    = (o_bvalid && (w_err || w_bad)) ? RESP_SLVERR : RESP_OKAY;
    assign o_wr_state = w_state;

endmodule
